clk_gen_multi: RTL
==================

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the free-running divider counter (minimum 4).
REQ-002 SHALL have parameter SEL_W, default 5: width of the tap-select input; SEL_W = ceil(log2(WIDTH)).
REQ-003 SHALL have parameter STEP_HI, default 4: number of clk cycles Clk_CPU is held high for one single-step pulse (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port sel, input, SEL_W bits: requested tap index. Values above WIDTH-1 are clamped to WIDTH-1.
REQ-007 SHALL have port halt, input, 1 bit: level request to stop the CPU clock.
REQ-008 SHALL have port step, input, 1 bit: single-step request, level input. Its rising edge is detected internally; it is assumed debounced externally.
REQ-009 SHALL have port clkdiv, output, WIDTH bits: free-running counter value.
REQ-010 SHALL have port Clk_CPU, output, 1 bit: registered, glitch-free CPU clock.
REQ-011 SHALL have port cpu_en, output, 1 bit: one-cycle pulse, coincident with each 0->1 transition of Clk_CPU.
REQ-012 SHALL have port act_sel, output, SEL_W bits: the tap currently driving Clk_CPU.
REQ-013 SHALL have port busy, output, 1 bit: high while in state SWITCH.

Function
REQ-014 clkdiv SHALL increment by 1 every cycle, modulo 2^WIDTH, independent of state. It wraps from all-ones to 0 with no other effect.
REQ-015 A tap rise SHALL mean that bit act_sel of clkdiv goes 0->1 across one clock edge. A tap fall SHALL mean that bit goes 1->0.
REQ-016 The block SHALL have four states:
- RUN: Clk_CPU equals clkdiv[act_sel] every cycle.
- SWITCH: Clk_CPU is held 0; act_sel <= clamp(sel) every cycle.
- HALT: Clk_CPU is held 0.
- STEP: Clk_CPU is held 1.
REQ-017 SWITCH->RUN SHALL occur on the first tap rise detected in any cycle after SWITCH is entered. On that edge Clk_CPU = 1 and cpu_en = 1.
REQ-018 In RUN, when halt = 1 or clamp(sel) != act_sel, the block SHALL remain in RUN until the next tap fall. At that fall it moves to HALT if halt = 1, otherwise to SWITCH. Clk_CPU is 0 on that edge, so no high phase is ever truncated.
REQ-019 If halt and a sel change are both pending in RUN, halt SHALL take priority.
REQ-020 In SWITCH, halt = 1 SHALL move the block to HALT on the next edge.
REQ-021 In HALT, halt = 0 SHALL move the block to SWITCH.
REQ-022 In HALT, a step rising edge (step = 1 while the registered previous step = 0) SHALL move the block to STEP. On that same edge Clk_CPU = 1 and cpu_en = 1.
REQ-023 STEP SHALL hold Clk_CPU = 1 for exactly STEP_HI cycles, then return to HALT with Clk_CPU = 0. Step edges during STEP SHALL be ignored.
REQ-024 Step edges in RUN or SWITCH SHALL be ignored and SHALL NOT be queued.
REQ-025 cpu_en SHALL be 1 exactly when Clk_CPU is 1 and was 0 on the previous cycle. Otherwise it is 0.
REQ-026 Every Clk_CPU high or low phase SHALL last at least 1 clk cycle. Clk_CPU SHALL be a flop output with no combinational path from inputs.

Reset
REQ-027 When rst = 1 at a clock edge, the block SHALL set:
- clkdiv = 0
- Clk_CPU = 0
- cpu_en = 0
- busy = 1
- state = SWITCH
- act_sel = 0
- the registered previous step = 0
REQ-028 rst SHALL override every state, including mid-STEP and mid-SWITCH. Normal operation resumes on the first edge with rst = 0.

Verification
REQ-029 Start-up: rst, then sel = 1, halt = 0.
- Required: clkdiv = 1, 2, 3, ...
- First Clk_CPU rise occurs at clkdiv = 2, with cpu_en = 1.
- Thereafter the period is 4 cycles, 2 high; busy = 0 once in RUN.
REQ-030 Rate switch: running with sel = 1, change sel to 3 at clkdiv = 6.
- Clk_CPU stays high through clkdiv = 7.
- Clk_CPU is low from clkdiv = 8 through 23; act_sel = 3 from clkdiv = 9.
- Clk_CPU rises at clkdiv = 24, then period is 16.
REQ-031 Clamp: WIDTH = 8, SEL_W = 3 with sel = 7 runs on tap 7. WIDTH = 12, SEL_W = 4 with sel = 15 gives act_sel = 11.
REQ-032 Halt and step: sel = 1, assert halt while Clk_CPU = 1.
- Clk_CPU falls at the next tap fall and stays 0.
- A step pulse gives exactly 4 high cycles with one cpu_en.
- A second step edge during those 4 cycles produces nothing extra.
REQ-033 Simultaneous requests and resume:
- Halt and a sel change in the same cycle go to HALT, not SWITCH.
- Dropping halt enters SWITCH; first rise is on the new tap.
REQ-034 Reset mid-STEP: Clk_CPU = 0, clkdiv = 0, busy = 1 on the reset edge. With the counter at all-ones, clkdiv wraps to 0 with no Clk_CPU glitch.

Source files
------------

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: free-running divider counter with a selectable tap that
// drives a registered, glitch-free CPU clock. Tap changes and halts only take
// effect at a tap fall, so no high phase is ever cut short. While halted, the
// CPU clock can be single-stepped for STEP_HI cycles at a time.
//
// Handshake note: there is no valid/ready pair in this block. halt and sel are
// level requests that are sampled every cycle. step is a level input whose
// rising edge is detected here. busy reports that a tap switch is in progress.
module clk_gen_multi #(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 5,
    parameter int STEP_HI = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             halt,
    input  logic             step,
    output logic [WIDTH-1:0] clkdiv,
    output logic             Clk_CPU,
    output logic             cpu_en,
    output logic [SEL_W-1:0] act_sel,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SWITCH = 2'd1,
        S_HALT   = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] MAX_TAP   = SEL_W'(WIDTH - 1);
    localparam int               CNT_W     = (STEP_HI > 1) ? $clog2(STEP_HI) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_HI - 1);

    state_t           state_q;
    logic [WIDTH-1:0] clkdiv_q;
    logic [WIDTH-1:0] clkdiv_d;
    logic [SEL_W-1:0] act_sel_q;
    logic [SEL_W-1:0] want_sel;
    logic [CNT_W-1:0] step_cnt_q;
    logic             clk_cpu_q;
    logic             cpu_en_q;
    logic             step_prev_q;
    logic             act_rise;
    logic             act_fall;
    logic             want_rise;
    logic             step_edge;

    // Next counter value, clamped tap request and tap edge detection.
    // Rises and falls compare the current counter with the next one, so the
    // CPU clock flop lands exactly on the counter bit it follows.
    always_comb begin
        clkdiv_d  = clkdiv_q + WIDTH'(1);
        want_sel  = ({1'b0, sel} > {1'b0, MAX_TAP}) ? MAX_TAP : sel;
        act_rise  = ~clkdiv_q[act_sel_q] & clkdiv_d[act_sel_q];
        act_fall  = clkdiv_q[act_sel_q] & ~clkdiv_d[act_sel_q];
        want_rise = ~clkdiv_q[want_sel] & clkdiv_d[want_sel];
        step_edge = step & ~step_prev_q;
    end

    // Counter, step edge register and the RUN/SWITCH/HALT/STEP controller.
    // In SWITCH the rise is detected on the newly requested tap, which is the
    // tap that becomes act_sel on that same edge.
    always_ff @(posedge clk) begin
        clkdiv_q    <= clkdiv_d;
        step_prev_q <= step;
        cpu_en_q    <= 1'b0;
        if (rst) begin
            clkdiv_q    <= '0;
            state_q     <= S_SWITCH;
            act_sel_q   <= '0;
            clk_cpu_q   <= 1'b0;
            step_prev_q <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    clk_cpu_q <= clkdiv_d[act_sel_q];
                    cpu_en_q  <= act_rise & ~clk_cpu_q;
                    if (act_fall) begin
                        if (halt) begin
                            state_q <= S_HALT;
                        end else if (want_sel != act_sel_q) begin
                            state_q <= S_SWITCH;
                        end
                    end
                end
                S_SWITCH: begin
                    act_sel_q <= want_sel;
                    clk_cpu_q <= 1'b0;
                    if (halt) begin
                        state_q <= S_HALT;
                    end else if (want_rise) begin
                        state_q   <= S_RUN;
                        clk_cpu_q <= 1'b1;
                        cpu_en_q  <= 1'b1;
                    end
                end
                S_HALT: begin
                    clk_cpu_q <= 1'b0;
                    if (!halt) begin
                        state_q <= S_SWITCH;
                    end else if (step_edge) begin
                        state_q    <= S_STEP;
                        clk_cpu_q  <= 1'b1;
                        cpu_en_q   <= 1'b1;
                        step_cnt_q <= STEP_LAST;
                    end
                end
                S_STEP: begin
                    if (step_cnt_q == '0) begin
                        state_q   <= S_HALT;
                        clk_cpu_q <= 1'b0;
                    end else begin
                        step_cnt_q <= step_cnt_q - CNT_W'(1);
                        clk_cpu_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_SWITCH;
                    clk_cpu_q <= 1'b0;
                end
            endcase
        end
    end

    assign clkdiv      = clkdiv_q;
    assign Clk_CPU     = clk_cpu_q;
    assign cpu_en      = cpu_en_q;
    assign act_sel     = act_sel_q;
    assign busy        = (state_q == S_SWITCH);
    assign dbg_state_o = state_q;

endmodule
